// File: rtl/payload_reader_pkg.sv
// Shared types for the payload drain path: buffer address/data widths,
// packet word counts and the output FIFO entry layout.
package payload_reader_pkg;

    localparam int PAYLOAD_DEPTH = 16;
    localparam int ADDR_W        = 10;
    localparam int DATA_W        = 32;
    localparam int BYTECNT_W     = 3;
    localparam int WORDCNT_W     = $clog2(PAYLOAD_DEPTH + 1);

    typedef logic [ADDR_W-1:0]    Address_t;
    typedef logic [DATA_W-1:0]    Data_t;
    typedef logic [BYTECNT_W-1:0] ByteCount_t;
    typedef logic [WORDCNT_W-1:0] WordCount_t;

    typedef struct packed {
        Data_t      data;
        ByteCount_t byte_count;
        logic       last;
    } fifo_entry_t;

    // A descriptor may only start a walk if its length fits the output FIFO.
    function automatic logic word_count_legal(input WordCount_t words, input int depth);
        return (words != {WORDCNT_W{1'b0}}) && (int'(words) <= depth);
    endfunction

endpackage

// File: rtl/payload_reader_if.sv
// Read bus between the payload buffer and its reader: the reader drives the
// walk start, the buffer returns one linked-list word per clock.
interface payload_reader_if;
    import payload_reader_pkg::*;

    Address_t   address;
    logic       isFirst;
    Data_t      data;
    ByteCount_t byteCount;
    logic       isLast;

    modport master (
        output address,
        output isFirst,
        input  data,
        input  byteCount,
        input  isLast
    );

    modport slave (
        input  address,
        input  isFirst,
        output data,
        output byteCount,
        output isLast
    );

endinterface

// File: rtl/payload_out_fifo.sv
// Synchronous egress FIFO with occupancy count; read side is taken straight
// from storage registers so the egress outputs carry no input-to-output path.
module payload_out_fifo
    import payload_reader_pkg::*;
#(
    parameter int DEPTH = PAYLOAD_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_push,
    input  fifo_entry_t                  i_push_entry,
    input  logic                         i_pop_ready,
    output logic                         o_valid,
    output fifo_entry_t                  o_entry,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fifo_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;

    assign w_empty = (r_count == {CNT_W{1'b0}});
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = ~w_empty & i_pop_ready;
    // A simultaneous pop frees the slot being written, so push is legal when full.
    assign w_push  = i_push & (~w_full | w_pop);

    assign o_valid = ~w_empty;
    assign o_entry = w_empty ? fifo_entry_t'({$bits(fifo_entry_t){1'b0}}) : r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until counted as valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

endmodule

// File: rtl/payload_reader.sv
// Drains packets from the payload buffer: accepts a descriptor only when the
// whole packet fits the egress FIFO, then walks the list one word per clock.
module payload_reader
    import payload_reader_pkg::*;
#(
    parameter int DEPTH = PAYLOAD_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_desc_valid,
    output logic                 o_desc_ready,
    input  Address_t             i_desc_head,
    input  WordCount_t           i_desc_words,
    output logic                 o_buf_req,
    input  logic                 i_buf_grant,
    output logic                 o_buf_enable,
    payload_reader_if.master     rdBus,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output Data_t                o_out_data,
    output ByteCount_t           o_out_byte_count,
    output logic                 o_out_last,
    output logic                 o_busy,
    output logic                 o_err_len
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    logic [1:0]   r_state;
    Address_t     r_head;
    WordCount_t   r_remaining;
    logic         r_err_len;

    WordCount_t   w_fifo_count;
    WordCount_t   w_space;
    logic         w_legal;
    logic         w_fits;
    logic         w_last_word;
    logic         w_desc_ready;
    logic         w_buf_req;
    logic         w_buf_enable;
    logic         w_is_first;
    Address_t     w_address;
    logic         w_push;
    fifo_entry_t  w_push_entry;
    fifo_entry_t  w_out_entry;

    assign w_legal      = word_count_legal(i_desc_words, DEPTH);
    assign w_space      = WordCount_t'(DEPTH) - w_fifo_count;
    assign w_fits       = (w_space >= i_desc_words);
    assign w_last_word  = (r_remaining == WordCount_t'(1));
    assign w_push_entry = {rdBus.data, rdBus.byteCount, w_last_word};

    // Handshake and buffer-control decode; everything is held low under reset.
    always_comb begin
        w_desc_ready = 1'b0;
        w_buf_req    = 1'b0;
        w_buf_enable = 1'b0;
        w_is_first   = 1'b0;
        w_address    = {ADDR_W{1'b0}};
        w_push       = 1'b0;
        if (reset) begin
            w_desc_ready = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_buf_req    = i_desc_valid;
                    // Illegal lengths are swallowed without waiting for the buffer.
                    w_desc_ready = i_desc_valid & (~w_legal | (i_buf_grant & w_fits));
                end
                ST_ISSUE: begin
                    w_buf_req    = 1'b1;
                    w_buf_enable = 1'b1;
                    w_is_first   = 1'b1;
                    w_address    = r_head;
                end
                ST_STREAM: begin
                    w_buf_req    = 1'b1;
                    w_buf_enable = 1'b1;
                    w_push       = 1'b1;
                end
                default: begin
                    w_buf_req    = 1'b0;
                end
            endcase
        end
    end

    // Walk sequencing and sticky length-error capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_head      <= {ADDR_W{1'b0}};
            r_remaining <= {WORDCNT_W{1'b0}};
            r_err_len   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_desc_ready && w_legal) begin
                        r_head      <= i_desc_head;
                        r_remaining <= i_desc_words;
                        r_state     <= ST_ISSUE;
                    end else if (w_desc_ready) begin
                        r_err_len   <= 1'b1;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    r_remaining <= r_remaining - WordCount_t'(1);
                    // The count is authoritative; a disagreeing isLast only flags.
                    if (rdBus.isLast != w_last_word) begin
                        r_err_len <= 1'b1;
                    end
                    if (w_last_word) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_STREAM;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    payload_out_fifo #(
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clock        (clock),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop_ready  (i_out_ready),
        .o_valid      (o_out_valid),
        .o_entry      (w_out_entry),
        .o_count      (w_fifo_count)
    );

    assign o_desc_ready     = w_desc_ready;
    assign o_buf_req        = w_buf_req;
    assign o_buf_enable     = w_buf_enable;
    assign rdBus.isFirst    = w_is_first;
    assign rdBus.address    = w_address;
    assign o_out_data       = w_out_entry.data;
    assign o_out_byte_count = w_out_entry.byte_count;
    assign o_out_last       = w_out_entry.last;
    assign o_busy           = ~reset & (r_state != ST_IDLE);
    assign o_err_len        = r_err_len;

endmodule

// File: tb/tb_payload_reader.sv
// Directed bench for payload_reader with a small linked-list buffer model
// returning word k of a walk as 0xD000_0000 | head<<8 | k.
module tb_payload_reader;
    import payload_reader_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        desc_valid;
    logic        desc_ready;
    Address_t    desc_head;
    WordCount_t  desc_words;
    logic        buf_req;
    logic        buf_grant;
    logic        buf_enable;
    logic        out_valid;
    logic        out_ready;
    Data_t       out_data;
    ByteCount_t  out_byte_count;
    logic        out_last;
    logic        busy;
    logic        err_len;

    int n_cmp = 0;
    int n_err = 0;

    logic [39:0] exp_q [$];

    payload_reader_if rd_if ();

    payload_reader #(.DEPTH(16)) dut (
        .clock            (clock),
        .reset            (reset),
        .i_desc_valid     (desc_valid),
        .o_desc_ready     (desc_ready),
        .i_desc_head      (desc_head),
        .i_desc_words     (desc_words),
        .o_buf_req        (buf_req),
        .i_buf_grant      (buf_grant),
        .o_buf_enable     (buf_enable),
        .rdBus            (rd_if),
        .o_out_valid      (out_valid),
        .i_out_ready      (out_ready),
        .o_out_data       (out_data),
        .o_out_byte_count (out_byte_count),
        .o_out_last       (out_last),
        .o_busy           (busy),
        .o_err_len        (err_len)
    );

    always #5 clock = ~clock;

    // Buffer model: word counter restarts on the isFirst cycle of a walk.
    Address_t   bm_base = 10'h000;
    logic [7:0] bm_k    = 8'd0;
    logic [7:0] last_at = 8'd0;

    always @(posedge clock) begin
        if (buf_enable && rd_if.isFirst) begin
            bm_k    <= 8'd1;
            bm_base <= rd_if.address;
        end else if (buf_enable) begin
            bm_k    <= bm_k + 8'd1;
        end
    end

    assign rd_if.data      = {4'hD, 10'h000, bm_base, bm_k};
    assign rd_if.byteCount = (bm_k == last_at) ? 3'd2 : 3'd4;
    assign rd_if.isLast    = (bm_k == last_at);

    function automatic logic [31:0] wd(input logic [9:0] head, input int k);
        return 32'hD000_0000 | ({22'd0, head} << 8) | k;
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int c = 0;
        while (busy && c < maxc) begin
            step();
            c++;
        end
        chk(tag, {39'd0, busy}, 40'd0);
    endtask

    // Pops words with out_ready high, comparing {last, data} against exp_q in order.
    task automatic drain_q(input string tag, input int maxc);
        int c = 0;
        int i = 0;
        out_ready = 1'b1;
        while (i < exp_q.size() && c < maxc) begin
            if (out_valid) begin
                chk(tag, {7'd0, out_last, out_data}, exp_q[i]);
                i++;
            end
            step();
            c++;
        end
        chk({tag, "_count"}, 40'(i), 40'(exp_q.size()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        desc_valid = 1'b1;
        desc_head  = 10'h000;
        desc_words = 5'd1;
        buf_grant  = 1'b1;
        out_ready  = 1'b0;
        step();
        step();
        chk("rst_desc_ready", {39'd0, desc_ready}, 40'd0);
        chk("rst_buf_req",    {39'd0, buf_req},    40'd0);
        chk("rst_buf_enable", {39'd0, buf_enable}, 40'd0);
        chk("rst_is_first",   {39'd0, rd_if.isFirst}, 40'd0);
        chk("rst_address",    {30'd0, rd_if.address}, 40'd0);
        chk("rst_out_valid",  {39'd0, out_valid},  40'd0);
        chk("rst_out_last",   {39'd0, out_last},   40'd0);
        chk("rst_busy",       {39'd0, busy},       40'd0);
        chk("rst_err_len",    {39'd0, err_len},    40'd0);
        desc_valid = 1'b0;
        reset      = 1'b0;
        step();

        // Single 3-word packet with egress always ready.
        last_at    = 8'd3;
        out_ready  = 1'b1;
        desc_head  = 10'h010;
        desc_words = 5'd3;
        desc_valid = 1'b1;
        #1;
        chk("p1_desc_ready", {39'd0, desc_ready}, 40'd1);
        chk("p1_buf_req",    {39'd0, buf_req},    40'd1);
        step();
        desc_valid = 1'b0;
        chk("p1_issue", {30'd0, buf_enable, rd_if.isFirst, rd_if.address}, {30'd0, 1'b1, 1'b1, 10'h010});
        chk("p1_busy",  {39'd0, busy}, 40'd1);
        step();
        chk("p1_stream_first", {38'd0, buf_enable, rd_if.isFirst}, {38'd0, 1'b1, 1'b0});
        chk("p1_no_early_valid", {39'd0, out_valid}, 40'd0);
        step();
        chk("p1_w1", {6'd0, out_valid, out_last, out_data}, {6'd0, 1'b1, 1'b0, wd(10'h010, 1)});
        step();
        chk("p1_w2", {6'd0, out_valid, out_last, out_data}, {6'd0, 1'b1, 1'b0, wd(10'h010, 2)});
        step();
        chk("p1_w3", {6'd0, out_valid, out_last, out_data}, {6'd0, 1'b1, 1'b1, wd(10'h010, 3)});
        chk("p1_w3_bytes", {37'd0, out_byte_count}, {37'd0, 3'd2});
        chk("p1_busy_low", {39'd0, busy}, 40'd0);
        step();
        chk("p1_drained", {39'd0, out_valid}, 40'd0);

        // Backpressure: two 8-word packets fill the FIFO, a third waits for space.
        out_ready  = 1'b0;
        last_at    = 8'd8;
        desc_head  = 10'h020;
        desc_words = 5'd8;
        desc_valid = 1'b1;
        #1;
        chk("bp_a_ready", {39'd0, desc_ready}, 40'd1);
        step();
        desc_valid = 1'b0;
        wait_idle("bp_a_idle", 20);
        desc_head  = 10'h040;
        desc_valid = 1'b1;
        #1;
        chk("bp_b_ready", {39'd0, desc_ready}, 40'd1);
        step();
        desc_valid = 1'b0;
        wait_idle("bp_b_idle", 20);
        chk("bp_head_word", {7'd0, out_valid, out_data}, {7'd0, 1'b1, wd(10'h020, 1)});
        chk("bp_err_clear", {39'd0, err_len}, 40'd0);
        last_at    = 8'd1;
        desc_head  = 10'h060;
        desc_words = 5'd1;
        desc_valid = 1'b1;
        #1;
        chk("bp_c_held",    {39'd0, desc_ready}, 40'd0);
        chk("bp_c_req",     {39'd0, buf_req},    40'd1);
        step();
        chk("bp_c_held2",   {39'd0, desc_ready}, 40'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        chk("bp_c_ready",   {39'd0, desc_ready}, 40'd1);
        step();
        desc_valid = 1'b0;
        chk("bp_stable_word", {7'd0, out_valid, out_data}, {7'd0, 1'b1, wd(10'h020, 2)});
        exp_q.delete();
        for (int k = 2; k <= 8; k++) exp_q.push_back({7'd0, (k == 8), wd(10'h020, k)});
        for (int k = 1; k <= 8; k++) exp_q.push_back({7'd0, (k == 8), wd(10'h040, k)});
        exp_q.push_back({7'd0, 1'b1, wd(10'h060, 1)});
        drain_q("bp_drain", 80);
        wait_idle("bp_end_idle", 10);

        // Buffer flags isLast on word 2 of a 4-word packet.
        last_at    = 8'd2;
        desc_head  = 10'h080;
        desc_words = 5'd4;
        desc_valid = 1'b1;
        #1;
        chk("len_ready", {39'd0, desc_ready}, 40'd1);
        step();
        desc_valid = 1'b0;
        exp_q.delete();
        for (int k = 1; k <= 4; k++) exp_q.push_back({7'd0, (k == 4), wd(10'h080, k)});
        drain_q("len_words", 20);
        chk("len_err", {39'd0, err_len}, 40'd1);

        // Grant withheld for five cycles.
        buf_grant  = 1'b0;
        last_at    = 8'd2;
        desc_head  = 10'h0A0;
        desc_words = 5'd2;
        desc_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("gnt_wait", {37'd0, buf_req, desc_ready, busy}, {37'd0, 1'b1, 1'b0, 1'b0});
            step();
        end
        buf_grant = 1'b1;
        #1;
        chk("gnt_ready", {39'd0, desc_ready}, 40'd1);
        step();
        desc_valid = 1'b0;
        chk("gnt_issue", {29'd0, buf_req, buf_enable, rd_if.isFirst, rd_if.address}, {29'd0, 1'b1, 1'b1, 1'b1, 10'h0A0});
        exp_q.delete();
        for (int k = 1; k <= 2; k++) exp_q.push_back({7'd0, (k == 2), wd(10'h0A0, k)});
        drain_q("gnt_words", 20);

        // Reset while word 5 of a 10-word packet is on the bus.
        last_at    = 8'd10;
        desc_head  = 10'h0C0;
        desc_words = 5'd10;
        desc_valid = 1'b1;
        #1;
        chk("mid_ready", {39'd0, desc_ready}, 40'd1);
        step();
        desc_valid = 1'b0;
        repeat (5) step();
        chk("mid_streaming", {38'd0, buf_enable, busy}, {38'd0, 1'b1, 1'b1});
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mid_after_rst", {36'd0, out_valid, buf_enable, busy, err_len}, 40'd0);

        // Illegal lengths: 0, then 17.
        desc_head  = 10'h0E0;
        desc_words = 5'd0;
        desc_valid = 1'b1;
        #1;
        chk("ill0_ready", {39'd0, desc_ready}, 40'd1);
        step();
        desc_valid = 1'b0;
        chk("ill0_err",  {37'd0, err_len, busy, buf_enable}, {37'd0, 1'b1, 1'b0, 1'b0});
        step();
        chk("ill0_quiet", {38'd0, busy, buf_enable}, 40'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("ill17_pre_err", {39'd0, err_len}, 40'd0);
        desc_words = 5'd17;
        desc_valid = 1'b1;
        #1;
        chk("ill17_ready", {39'd0, desc_ready}, 40'd1);
        step();
        desc_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("ill17_quiet", {38'd0, busy, buf_enable}, 40'd0);
            step();
        end
        chk("ill17_err", {39'd0, err_len}, 40'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
